color_manager: RTL and testbench
================================

COLOR_MANAGER -- requirements
Module: color_manager

Interface
REQ-001 Parameter UART_DATA_WIDTH, 8, width of the received UART byte.
REQ-002 Parameter C_ADDR_WIDTH, 2, quadrant address width.
REQ-003 Parameter C_DATA_WIDTH, 10, packed colour width.
REQ-004 Parameters CONFIG_STATUS_WIDTH, CONFIG_NOTIFICATION_WIDTH and CONFIG_ERROR_WIDTH, each 2, status/notification/error code widths.
REQ-005 Parameter VGA_NOTIFICATION_WIDTH, 3, display-mode code width.
REQ-006 Parameter DATA_WIDTH, 10, pixel colour width on Data_VGA.
REQ-007 Parameters H_HALF, 320, and V_HALF, 240, quadrant boundaries in clocks and lines.
REQ-008 Clk  in  1  single clock; all logic on its rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 Empty  in  1  upstream FIFO empty; 0 = RXD_Data valid this cycle.
REQ-011 RXD_Data  in  UART_DATA_WIDTH  received byte.
REQ-012 C_Rdy  in  1  colour sink ready.
REQ-013 Vertical_Split / Horizontal_Split / VGA_debug  in  1 each  display-mode selects.
REQ-014 HSync / VSync  in  1 each  line and frame sync.
REQ-015 C_Addr  out  C_ADDR_WIDTH  and  C_Data  out  C_DATA_WIDTH  colour write address and data.
REQ-016 C_Valid  out  1  colour write request.
REQ-017 Config_Status  out  2  FSM state code.
REQ-018 Config_Notification  out  2  and  Config_Notification_Valid  out  1  quadrant written, plus 1-cycle strobe.
REQ-019 Config_Error  out  2  and  Error_Valid  out  1  error code, plus 1-cycle strobe.
REQ-020 VGA_Notification  out  3  and  VGA_Notification_Valid  out  1  display mode, plus change strobe.
REQ-021 Data_VGA  out  DATA_WIDTH  current pixel colour.

Function
REQ-022 A byte shall be consumed on every rising edge where Empty=0.
REQ-023 Command = two bytes: byte1 bits[7:6]=00, [5:4]=quadrant (00 left-up, 01 right-up, 11 right-down, 10 left-down), [3:0]=colour[9:6]; byte2 bits[7:6]=01, [5:0]=colour[5:0].
REQ-024 FSM states, encoded on Config_Status: IDLE=00, WAIT_DATA=01, WRITE=10.
- IDLE: a valid byte1 moves to WAIT_DATA.
- WAIT_DATA: a valid byte2 moves to WRITE.
REQ-025 On entry to WRITE: C_Valid=1, with C_Addr and C_Data held stable until C_Rdy=1 is sampled.
- On that edge: internal colour register updated, Config_Notification=quadrant with Config_Notification_Valid=1 for one cycle.
- C_Valid=0 and state IDLE on the next cycle.
REQ-026 Error codes, each with Error_Valid pulsed for one cycle:
- 01 = bad tag in IDLE; byte dropped, stay IDLE.
- 10 = bad tag in WAIT_DATA; command aborted, go IDLE.
- 11 = byte received in WRITE; byte dropped, write continues.
REQ-027 Position tracking, using synchronously edge-detected HSync and VSync:
- h_cnt increments every clock and clears on HSync rise.
- v_cnt increments on HSync rise and clears on VSync rise.
- Both are 11-bit, saturating.
REQ-028 Quadrant selection: left = Vertical_Split=0 or h_cnt<H_HALF; up = Horizontal_Split=0 or v_cnt<V_HALF. Data_VGA = stored colour of the selected quadrant, registered with one-cycle latency.
REQ-029 VGA_debug=1 shall force Data_VGA to all ones.
REQ-030 VGA_Notification = {VGA_debug, Horizontal_Split, Vertical_Split}, registered; VGA_Notification_Valid pulses one cycle on any change.

Reset
REQ-031 While rst_n=0, all outputs shall be 0, the FSM shall be in IDLE, and the counters and all four colour registers shall be 0; a partial command shall be discarded.

Structure
REQ-032 A shared package shall hold the width parameters, state codes, error codes, quadrant codes and DEBUG_COLOR.
REQ-033 One sub-module, vga_position_tracker (sync edge detection and counters), shall be used; the FSM, colour bank and mux stay at top level.

Verification
REQ-034 Release reset; send 0x0A then 0x5A with C_Rdy=0 -> C_Valid=1, C_Addr=00, C_Data=0x29A held; raise C_Rdy -> one Config_Notification_Valid with value 00, C_Valid=0 next cycle.
REQ-035 Send 0x1A, 0x5F with C_Rdy=1 -> write to addr 01 data 0x29F; with both splits=1 and h_cnt>=H_HALF, v_cnt<V_HALF -> Data_VGA=0x29F.
REQ-036 Send 0x2A then 0x00 -> Config_Error=10 with Error_Valid pulse, no C_Valid, Config_Status returns to 00.
REQ-037 Send 0xC0 in IDLE -> Config_Error=01; send a byte while C_Valid=1, C_Rdy=0 -> Config_Error=11 and the pending write is unchanged.
REQ-038 Set Vertical_Split=Horizontal_Split=1 -> VGA_Notification=011 with one Valid pulse; then VGA_debug=1 -> Data_VGA=0x3FF.
REQ-039 Assert rst_n=0 while in WAIT_DATA -> all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/color_manager_pkg.sv
// Shared widths, protocol codes and quadrant helpers for the colour manager.
package color_manager_pkg;

  localparam int UART_W      = 8;
  localparam int ADDR_W      = 2;
  localparam int COLOR_W     = 10;
  localparam int STATUS_W    = 2;
  localparam int NOTIF_W     = 2;
  localparam int ERROR_W     = 2;
  localparam int VGA_NOTIF_W = 3;
  localparam int PIXEL_W     = 10;
  localparam int CNT_W       = 11;
  localparam int H_HALF_DEF  = 320;
  localparam int V_HALF_DEF  = 240;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_DATA = 2'b01,
    ST_WRITE     = 2'b10
  } state_t;

  localparam logic [1:0] TAG_FIRST  = 2'b00;
  localparam logic [1:0] TAG_SECOND = 2'b01;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_IDLE_TAG = 2'b01;
  localparam logic [1:0] ERR_WAIT_TAG = 2'b10;
  localparam logic [1:0] ERR_BUSY     = 2'b11;

  localparam logic [1:0] QUAD_LU = 2'b00;
  localparam logic [1:0] QUAD_RU = 2'b01;
  localparam logic [1:0] QUAD_LD = 2'b10;
  localparam logic [1:0] QUAD_RD = 2'b11;

  localparam logic [PIXEL_W-1:0] DEBUG_COLOR = '1;

  function automatic logic [1:0] quad_of(input logic left, input logic up);
    case ({left, up})
      2'b11:   return QUAD_LU;
      2'b01:   return QUAD_RU;
      2'b10:   return QUAD_LD;
      default: return QUAD_RD;
    endcase
  endfunction

endpackage

// File: rtl/vga_position_tracker.sv
// Tracks the beam position: clocks since the last HSync rise and lines since the last VSync rise.
module vga_position_tracker
  import color_manager_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync,
  input  logic             vsync,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  logic hsync_q;
  logic vsync_q;
  logic h_rise;
  logic v_rise;

  assign h_rise = hsync & ~hsync_q;
  assign v_rise = vsync & ~vsync_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (h_rise)           h_cnt <= '0;
      else if (h_cnt != '1) h_cnt <= h_cnt + 1'b1;
      // Frame restart wins over a coincident line increment.
      if (v_rise)                     v_cnt <= '0;
      else if (h_rise && v_cnt != '1) v_cnt <= v_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/color_manager.sv
// Parses two-byte UART colour commands into a four-quadrant colour bank and drives the VGA pixel colour.
module color_manager
  import color_manager_pkg::*;
#(
  parameter int UART_DATA_WIDTH           = UART_W,
  parameter int C_ADDR_WIDTH              = ADDR_W,
  parameter int C_DATA_WIDTH              = COLOR_W,
  parameter int CONFIG_STATUS_WIDTH       = STATUS_W,
  parameter int CONFIG_NOTIFICATION_WIDTH = NOTIF_W,
  parameter int CONFIG_ERROR_WIDTH        = ERROR_W,
  parameter int VGA_NOTIFICATION_WIDTH    = VGA_NOTIF_W,
  parameter int DATA_WIDTH                = PIXEL_W,
  parameter int H_HALF                    = H_HALF_DEF,
  parameter int V_HALF                    = V_HALF_DEF
)(
  input  logic                                 Clk,
  input  logic                                 rst_n,
  input  logic                                 Empty,
  input  logic [UART_DATA_WIDTH-1:0]           RXD_Data,
  input  logic                                 C_Rdy,
  input  logic                                 Vertical_Split,
  input  logic                                 Horizontal_Split,
  input  logic                                 VGA_debug,
  input  logic                                 HSync,
  input  logic                                 VSync,
  output logic [C_ADDR_WIDTH-1:0]              C_Addr,
  output logic [C_DATA_WIDTH-1:0]              C_Data,
  output logic                                 C_Valid,
  output logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
  output logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  output logic                                 Config_Notification_Valid,
  output logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  output logic                                 Error_Valid,
  output logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  output logic                                 VGA_Notification_Valid,
  output logic [DATA_WIDTH-1:0]                Data_VGA
);

  state_t                  state, state_next;
  logic                    byte_valid;
  logic [1:0]              tag;
  logic                    take_first, take_second, write_fire, err_fire;
  logic [1:0]              err_code;
  logic [C_ADDR_WIDTH-1:0] pend_addr;
  logic [C_DATA_WIDTH-1:0] pend_data;
  logic [C_DATA_WIDTH-1:0] bank [4];
  logic [CNT_W-1:0]        h_cnt, v_cnt;
  logic [1:0]              quad_sel;
  logic [2:0]              vga_mode;

  assign byte_valid = ~Empty;
  assign tag        = RXD_Data[UART_DATA_WIDTH-1 -: 2];

  vga_position_tracker u_tracker (
    .clk   (Clk),
    .rst_n (rst_n),
    .hsync (HSync),
    .vsync (VSync),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt)
  );

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    take_first  = 1'b0;
    take_second = 1'b0;
    write_fire  = 1'b0;
    err_fire    = 1'b0;
    err_code    = ERR_NONE;
    case (state)
      ST_IDLE: if (byte_valid) begin
        if (tag == TAG_FIRST) begin
          take_first = 1'b1;
          state_next = ST_WAIT_DATA;
        end else begin
          err_fire = 1'b1;
          err_code = ERR_IDLE_TAG;
        end
      end
      ST_WAIT_DATA: if (byte_valid) begin
        if (tag == TAG_SECOND) begin
          take_second = 1'b1;
          state_next  = ST_WRITE;
        end else begin
          err_fire   = 1'b1;
          err_code   = ERR_WAIT_TAG;
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // A byte arriving mid-write is dropped; the pending write is untouched.
        if (byte_valid) begin
          err_fire = 1'b1;
          err_code = ERR_BUSY;
        end
        if (C_Rdy) begin
          write_fire = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    C_Valid       = (state == ST_WRITE);
    C_Addr        = (state == ST_WRITE) ? pend_addr : '0;
    C_Data        = (state == ST_WRITE) ? pend_data : '0;
    Config_Status = CONFIG_STATUS_WIDTH'(state);
  end

  // NOTE: the colour bank is reset explicitly because the display reads it straight after reset.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr                 <= '0;
      pend_data                 <= '0;
      for (int i = 0; i < 4; i++) bank[i] <= '0;
      Config_Notification       <= '0;
      Config_Notification_Valid <= 1'b0;
      Config_Error              <= '0;
      Error_Valid               <= 1'b0;
    end else begin
      if (take_first) begin
        pend_addr                     <= RXD_Data[5:4];
        pend_data[C_DATA_WIDTH-1 -: 4] <= RXD_Data[3:0];
      end
      if (take_second) pend_data[5:0] <= RXD_Data[5:0];
      if (write_fire) begin
        bank[pend_addr]     <= pend_data;
        Config_Notification <= CONFIG_NOTIFICATION_WIDTH'(pend_addr);
      end
      Config_Notification_Valid <= write_fire;
      if (err_fire) Config_Error <= CONFIG_ERROR_WIDTH'(err_code);
      Error_Valid <= err_fire;
    end
  end

  assign quad_sel = quad_of(~Vertical_Split   || (h_cnt < CNT_W'(H_HALF)),
                            ~Horizontal_Split || (v_cnt < CNT_W'(V_HALF)));
  assign vga_mode = {VGA_debug, Horizontal_Split, Vertical_Split};

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      Data_VGA               <= '0;
      VGA_Notification       <= '0;
      VGA_Notification_Valid <= 1'b0;
    end else begin
      Data_VGA               <= VGA_debug ? DATA_WIDTH'(DEBUG_COLOR) : DATA_WIDTH'(bank[quad_sel]);
      VGA_Notification       <= VGA_NOTIFICATION_WIDTH'(vga_mode);
      VGA_Notification_Valid <= (VGA_NOTIFICATION_WIDTH'(vga_mode) != VGA_Notification);
    end
  end

endmodule

// File: tb/tb_color_manager.sv
// Randomised and directed bench for color_manager against a command-level reference model.
module tb_color_manager;

  logic       Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Empty = 1'b1;
  logic [7:0] RXD_Data = 8'h00;
  logic       C_Rdy = 1'b0;
  logic       Vertical_Split = 1'b0;
  logic       Horizontal_Split = 1'b0;
  logic       VGA_debug = 1'b0;
  logic       HSync = 1'b0;
  logic       VSync = 1'b0;
  logic [1:0] C_Addr;
  logic [9:0] C_Data;
  logic       C_Valid;
  logic [1:0] Config_Status;
  logic [1:0] Config_Notification;
  logic       Config_Notification_Valid;
  logic [1:0] Config_Error;
  logic       Error_Valid;
  logic [2:0] VGA_Notification;
  logic       VGA_Notification_Valid;
  logic [9:0] Data_VGA;

  color_manager dut (
    .Clk                       (Clk),
    .rst_n                     (rst_n),
    .Empty                     (Empty),
    .RXD_Data                  (RXD_Data),
    .C_Rdy                     (C_Rdy),
    .Vertical_Split            (Vertical_Split),
    .Horizontal_Split          (Horizontal_Split),
    .VGA_debug                 (VGA_debug),
    .HSync                     (HSync),
    .VSync                     (VSync),
    .C_Addr                    (C_Addr),
    .C_Data                    (C_Data),
    .C_Valid                   (C_Valid),
    .Config_Status             (Config_Status),
    .Config_Notification       (Config_Notification),
    .Config_Notification_Valid (Config_Notification_Valid),
    .Config_Error              (Config_Error),
    .Error_Valid               (Error_Valid),
    .VGA_Notification          (VGA_Notification),
    .VGA_Notification_Valid    (VGA_Notification_Valid),
    .Data_VGA                  (Data_VGA)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a command is "first byte held" (queue) or "write outstanding" (busy).
  logic [7:0] partial[$];
  bit         busy;
  bit [1:0]   w_addr;
  bit [9:0]   w_data;
  bit [9:0]   m_bank[4];
  int         m_h, m_v;
  bit         hs_prev, vs_prev;
  bit [9:0]   m_dvga;
  bit [2:0]   m_mode;
  bit         m_mode_v;
  bit [1:0]   m_notif, m_err;
  bit         m_notif_v, m_err_v;

  function automatic int quad_index(input int h, input int v, input bit vs, input bit hs);
    bit left, up;
    left = !vs || (h < 320);
    up   = !hs || (v < 240);
    if (left && up) return 0;
    if (up)         return 1;
    if (left)       return 2;
    return 3;
  endfunction

  task automatic model_reset();
    partial.delete();
    busy = 0; w_addr = 0; w_data = 0;
    for (int i = 0; i < 4; i++) m_bank[i] = 0;
    m_h = 0; m_v = 0; hs_prev = 0; vs_prev = 0;
    m_dvga = 0; m_mode = 0; m_mode_v = 0;
    m_notif = 0; m_err = 0; m_notif_v = 0; m_err_v = 0;
  endtask

  task automatic model_step();
    logic [7:0] b0;
    bit h_rise, v_rise;
    m_dvga   = VGA_debug ? 10'h3FF : m_bank[quad_index(m_h, m_v, Vertical_Split, Horizontal_Split)];
    m_mode_v = ({VGA_debug, Horizontal_Split, Vertical_Split} != m_mode);
    m_mode   = {VGA_debug, Horizontal_Split, Vertical_Split};
    h_rise = HSync && !hs_prev;
    v_rise = VSync && !vs_prev;
    hs_prev = HSync;
    vs_prev = VSync;
    if (h_rise) m_h = 0; else if (m_h < 2047) m_h++;
    if (v_rise) m_v = 0; else if (h_rise && m_v < 2047) m_v++;
    m_notif_v = 0;
    m_err_v   = 0;
    if (busy) begin
      if (!Empty) begin m_err = 3; m_err_v = 1; end
      if (C_Rdy) begin
        m_bank[w_addr] = w_data;
        m_notif = w_addr; m_notif_v = 1; busy = 0;
      end
    end else if (partial.size() == 0) begin
      if (!Empty) begin
        if (RXD_Data[7:6] == 2'b00) partial.push_back(RXD_Data);
        else begin m_err = 1; m_err_v = 1; end
      end
    end else if (!Empty) begin
      b0 = partial.pop_front();
      if (RXD_Data[7:6] == 2'b01) begin
        busy = 1; w_addr = b0[5:4]; w_data = {b0[3:0], RXD_Data[5:0]};
      end else begin
        m_err = 2; m_err_v = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("c_valid",   C_Valid, busy);
    check("status",    Config_Status, busy ? 2 : (partial.size() != 0 ? 1 : 0));
    check("c_addr",    C_Addr, busy ? w_addr : 0);
    check("c_data",    C_Data, busy ? w_data : 0);
    check("notif",     Config_Notification, m_notif);
    check("notif_v",   Config_Notification_Valid, m_notif_v);
    check("err",       Config_Error, m_err);
    check("err_v",     Error_Valid, m_err_v);
    check("vga_mode",  VGA_Notification, m_mode);
    check("vga_mode_v", VGA_Notification_Valid, m_mode_v);
    check("data_vga",  Data_VGA, m_dvga);
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_byte(input logic [7:0] b);
    Empty = 1'b0;
    RXD_Data = b;
    cycle();
    Empty = 1'b1;
  endtask

  task automatic hsync_pulse();
    HSync = 1'b1; cycle(); HSync = 1'b0; cycle();
  endtask

  // Reset asserted away from the clock edge; outputs must clear without a clock.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge Clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    idle(2);

    // Write held until the sink is ready.
    C_Rdy = 1'b0;
    send_byte(8'h0A);
    send_byte(8'h5A);
    idle(3);
    check("held_valid", C_Valid, 1);
    check("held_addr",  C_Addr, 0);
    check("held_data",  C_Data, 10'h29A);
    C_Rdy = 1'b1;
    cycle();
    check("ack_notif_v", Config_Notification_Valid, 1);
    check("ack_valid",   C_Valid, 0);
    cycle();
    check("ack_notif_once", Config_Notification_Valid, 0);

    // Fill the remaining quadrants with distinct colours.
    send_byte(8'h1A); send_byte(8'h5F); idle(2);
    send_byte(8'h31); send_byte(8'h55); idle(2);
    send_byte(8'h22); send_byte(8'h7C); idle(2);

    // Right-up quadrant: both splits, long line, first rows.
    Horizontal_Split = 1'b1;
    Vertical_Split   = 1'b1;
    cycle();
    check("mode_011",   VGA_Notification, 3'b011);
    check("mode_pulse", VGA_Notification_Valid, 1);
    cycle();
    check("mode_once",  VGA_Notification_Valid, 0);
    VSync = 1'b1; cycle(); VSync = 1'b0;
    hsync_pulse();
    idle(330);
    check("ru_pixel", Data_VGA, 10'h29F);

    // Abort on bad second tag.
    send_byte(8'h2A);
    send_byte(8'h00);
    check("abort_err",    Config_Error, 2'b10);
    check("abort_err_v",  Error_Valid, 1);
    check("abort_status", Config_Status, 0);
    check("abort_valid",  C_Valid, 0);

    // Bad tag in idle, then a byte during a stalled write.
    send_byte(8'hC0);
    check("idle_err", Config_Error, 2'b01);
    C_Rdy = 1'b0;
    send_byte(8'h0F);
    send_byte(8'h41);
    send_byte(8'h99);
    check("busy_err",  Config_Error, 2'b11);
    check("busy_data", C_Data, 10'h3C1);
    idle(2);
    C_Rdy = 1'b1;
    idle(2);

    // Debug colour override.
    VGA_debug = 1'b1;
    idle(2);
    check("debug_pixel", Data_VGA, 10'h3FF);
    VGA_debug = 1'b0;
    idle(2);

    // Sweep rows past the vertical boundary, then saturate both counters.
    VSync = 1'b1; cycle(); VSync = 1'b0;
    repeat (300) hsync_pulse();
    idle(400);
    idle(1800);
    repeat (2100) hsync_pulse();
    idle(5);

    // Reset in the middle of a command.
    send_byte(8'h0A);
    check("mid_status", Config_Status, 1);
    do_reset();
    check("rst_status", Config_Status, 0);
    idle(3);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      Empty = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       RXD_Data = {2'b00, 6'($urandom())};
        1:       RXD_Data = {2'b01, 6'($urandom())};
        default: RXD_Data = 8'($urandom());
      endcase
      C_Rdy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) Vertical_Split   = ~Vertical_Split;
      if ($urandom_range(0, 49) == 0) Horizontal_Split = ~Horizontal_Split;
      if ($urandom_range(0, 79) == 0) VGA_debug        = ~VGA_debug;
      HSync = ($urandom_range(0, 30) == 0);
      VSync = ($urandom_range(0, 400) == 0);
      cycle();
    end
    Empty = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
